// File: rtl/exe_mem_stage_pkg.sv
// rtl/exe_mem_stage_pkg.sv - shared widths, status bit positions and EXE->MEM payload type
package exe_mem_stage_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int REG_W_DEF       = 4;
  localparam int STALL_CNT_W_DEF = 16;

  // Status register layout is {Z,C,N,V}
  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_N = 1;
  localparam int SR_V = 0;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] store_val;
    logic [REG_W_DEF-1:0]  dest;
    logic                  mem_r;
    logic                  mem_w;
    logic                  wb_en;
  } exe_mem_payload_t;

endpackage

// File: rtl/exe_mem_stage_if.sv
// rtl/exe_mem_stage_if.sv - EXE-side and MEM-side signal bundle of the EXE/MEM stage
interface exe_mem_stage_if
  import exe_mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   flush;
  logic                   in_s;
  logic [3:0]             in_sr;
  logic [DATA_W-1:0]      in_alu_result;
  logic [DATA_W-1:0]      in_store_val;
  logic [REG_W-1:0]       in_dest;
  logic                   in_mem_r;
  logic                   in_mem_w;
  logic                   in_wb_en;
  logic [3:0]             status;
  logic                   c_out_to_alu;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_alu_result;
  logic [DATA_W-1:0]      out_store_val;
  logic [REG_W-1:0]       out_dest;
  logic                   out_mem_r;
  logic                   out_mem_w;
  logic                   out_wb_en;
  logic [STALL_CNT_W-1:0] stall_count;

  modport slave (
    input  in_valid, flush, in_s, in_sr, in_alu_result, in_store_val, in_dest,
           in_mem_r, in_mem_w, in_wb_en, out_ready,
    output in_ready, status, c_out_to_alu, out_valid, out_alu_result, out_store_val,
           out_dest, out_mem_r, out_mem_w, out_wb_en, stall_count
  );

  modport master (
    output in_valid, flush, in_s, in_sr, in_alu_result, in_store_val, in_dest,
           in_mem_r, in_mem_w, in_wb_en, out_ready,
    input  in_ready, status, c_out_to_alu, out_valid, out_alu_result, out_store_val,
           out_dest, out_mem_r, out_mem_w, out_wb_en, stall_count
  );

endinterface

// File: rtl/exe_mem_stage_skid_buffer.sv
// rtl/exe_mem_stage_skid_buffer.sv - generic 2-entry valid/ready skid buffer
module exe_mem_stage_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         push;
  logic         pop;

  // in_ready depends only on registered state, so out_ready never reaches it
  assign in_ready  = ~skid_valid;
  assign push      = in_valid & ~skid_valid;
  assign pop       = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (!main_valid || pop) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= push;
        if (push) main_data <= in_data;
      end
    end else if (push) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/exe_mem_stage.sv
// rtl/exe_mem_stage.sv - EXE/MEM pipeline stage with NZCV register; EXE_STALL_CNT_EN adds a stall counter
module exe_mem_stage
  import exe_mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  exe_mem_stage_if.slave  bus
);

  localparam int PW = 2 * DATA_W + REG_W + 3;

  exe_mem_payload_t in_pl;
  exe_mem_payload_t out_pl;
  logic [PW-1:0]    in_vec;
  logic [PW-1:0]    out_vec;
  logic             accept;
  logic [3:0]       status_q;

  assign in_pl.alu_result = bus.in_alu_result;
  assign in_pl.store_val  = bus.in_store_val;
  assign in_pl.dest       = bus.in_dest;
  assign in_pl.mem_r      = bus.in_mem_r;
  assign in_pl.mem_w      = bus.in_mem_w;
  assign in_pl.wb_en      = bus.in_wb_en;
  assign in_vec           = in_pl;
  assign out_pl           = out_vec;

  // Flush kills only the instruction presented now; buffered entries are older
  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

  exe_mem_stage_skid_buffer #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid & ~bus.flush),
    .in_ready  (bus.in_ready),
    .in_data   (in_vec),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_vec)
  );

  assign bus.out_alu_result = out_pl.alu_result;
  assign bus.out_store_val  = out_pl.store_val;
  assign bus.out_dest       = out_pl.dest;
  assign bus.out_mem_r      = out_pl.mem_r;
  assign bus.out_mem_w      = out_pl.mem_w;
  assign bus.out_wb_en      = out_pl.wb_en;

  // Flags commit on acceptance, so the next EXE instruction sees them even if MEM stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 4'b0000;
    end else if (accept && bus.in_s) begin
      status_q <= bus.in_sr;
    end
  end

  assign bus.status       = status_q;
  assign bus.c_out_to_alu = status_q[SR_C];

`ifdef EXE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.out_valid && !bus.out_ready && !(&stall_q)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_count = stall_q;
`else
  assign bus.stall_count = {STALL_CNT_W{1'b0}};
`endif

endmodule
